// File: rtl/transmitter.sv
// transmitter: host-bound framing engine for the proto245 TX path.
// Accepts a command (8-bit code + 32-bit data) and writes an 8-byte frame
// AA 00 code d[31:24] d[23:16] d[15:8] d[7:0] 55 into the TX FIFO. For
// BURST_CODE frames, N = data[15:0] raw payload bytes follow, passed through
// from the payload byte interface.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   cmd_valid/ready     command handshake; cmd_code, cmd_data latched on accept
//   pay_valid/ready     payload byte handshake; pay_data passed through
//   busy                frame in progress
//   frame_done          one-cycle pulse after the last byte of a frame
//   txfifo_load         FIFO occupancy (informational, unused)
//   txfifo_full         FIFO full backpressure
//   txfifo_wr, txfifo_data  FIFO write strobe and byte
module transmitter #(
  parameter int unsigned TX_FIFO_LOAD_W = 13,
  parameter logic [7:0]  BURST_CODE     = 8'h02
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [7:0]                cmd_code,
  input  logic [31:0]               cmd_data,
  input  logic                      pay_valid,
  output logic                      pay_ready,
  input  logic [7:0]                pay_data,
  output logic                      busy,
  output logic                      frame_done,
  input  logic [TX_FIFO_LOAD_W-1:0] txfifo_load,
  input  logic                      txfifo_full,
  output logic                      txfifo_wr,
  output logic [7:0]                txfifo_data
);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  state_t      state;
  logic [7:0]  code_q;
  logic [31:0] data_q;
  logic [2:0]  idx;
  logic [15:0] cnt;
  logic [7:0]  hdr_byte;

  // Occupancy is not needed by the control logic.
  logic unused_load;
  assign unused_load = ^txfifo_load;

  assign busy = (state != IDLE);

  always_comb begin
    hdr_byte = 8'h00;
    case (idx)
      3'd0: hdr_byte = 8'hAA;
      3'd1: hdr_byte = 8'h00;
      3'd2: hdr_byte = code_q;
      3'd3: hdr_byte = data_q[31:24];
      3'd4: hdr_byte = data_q[23:16];
      3'd5: hdr_byte = data_q[15:8];
      3'd6: hdr_byte = data_q[7:0];
      3'd7: hdr_byte = 8'h55;
      default: hdr_byte = 8'h00;
    endcase
  end

  // Write strobe and data follow the FIFO full flag combinationally so a
  // byte is held (not skipped) for as long as the FIFO stays full.
  always_comb begin
    pay_ready   = 1'b0;
    txfifo_wr   = 1'b0;
    txfifo_data = '0;
    case (state)
      HEADER: begin
        txfifo_wr   = !txfifo_full;
        txfifo_data = hdr_byte;
      end
      PAYLOAD: begin
        pay_ready   = !txfifo_full;
        txfifo_wr   = pay_valid && !txfifo_full;
        txfifo_data = pay_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      code_q     <= '0;
      data_q     <= '0;
      idx        <= '0;
      cnt        <= '0;
      cmd_ready  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            code_q    <= cmd_code;
            data_q    <= cmd_data;
            idx       <= '0;
            state     <= HEADER;
            cmd_ready <= 1'b0;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        HEADER: begin
          if (txfifo_wr) begin
            idx <= idx + 3'd1;
            if (idx == 3'd7) begin
              if (code_q == BURST_CODE && data_q[15:0] != 16'd0) begin
                cnt   <= data_q[15:0];
                state <= PAYLOAD;
              end else begin
                state      <= IDLE;
                frame_done <= 1'b1;
                cmd_ready  <= 1'b1;
              end
            end
          end
        end
        PAYLOAD: begin
          if (txfifo_wr) begin
            cnt <= cnt - 16'd1;
            if (cnt == 16'd1) begin
              state      <= IDLE;
              frame_done <= 1'b1;
              cmd_ready  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_transmitter.sv
// tb_transmitter: self-checking bench for transmitter. A queue-based frame
// model predicts every output each cycle; directed frames pin the model with
// literal byte streams and cycle offsets, then randomized frames follow.
module tb_transmitter;

  localparam logic [7:0] BURST = 8'h02;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_code;
  logic [31:0] cmd_data;
  logic        pay_valid;
  logic        pay_ready;
  logic [7:0]  pay_data;
  logic        busy;
  logic        frame_done;
  logic [12:0] txfifo_load;
  logic        txfifo_full;
  logic        txfifo_wr;
  logic [7:0]  txfifo_data;

  always #5 clk = ~clk;

  transmitter #(
    .TX_FIFO_LOAD_W(13),
    .BURST_CODE    (8'h02)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_code   (cmd_code),
    .cmd_data   (cmd_data),
    .pay_valid  (pay_valid),
    .pay_ready  (pay_ready),
    .pay_data   (pay_data),
    .busy       (busy),
    .frame_done (frame_done),
    .txfifo_load(txfifo_load),
    .txfifo_full(txfifo_full),
    .txfifo_wr  (txfifo_wr),
    .txfifo_data(txfifo_data)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_to(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_hdr[$];
  int         m_pay    = 0;
  bit         m_active = 0;
  bit         m_done   = 0;
  bit         m_crdy   = 0;
  bit         m_jr     = 1;
  bit         mon_en   = 0;

  logic [7:0] wlog[$];
  int         wcyc[$];
  int         dcyc[$];
  int         acyc[$];

  always @(negedge clk) begin
    logic       e_wr;
    logic       e_pr;
    logic [7:0] e_d;
    bit         chk_d;
    if (mon_en) begin
      e_wr  = 1'b0;
      e_pr  = 1'b0;
      e_d   = 8'h00;
      chk_d = m_jr;
      if (m_active && m_hdr.size() > 0) begin
        e_wr  = !txfifo_full;
        e_d   = m_hdr[0];
        chk_d = 1;
      end else if (m_active) begin
        e_pr  = !txfifo_full;
        e_wr  = pay_valid && !txfifo_full;
        e_d   = pay_data;
        chk_d = e_wr;
      end
      chk("busy", {31'd0, busy}, {31'd0, m_active});
      chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, m_crdy});
      chk("pay_ready", {31'd0, pay_ready}, {31'd0, e_pr});
      chk("txfifo_wr", {31'd0, txfifo_wr}, {31'd0, e_wr});
      chk("frame_done", {31'd0, frame_done}, {31'd0, m_done});
      if (chk_d) chk("txfifo_data", {24'd0, txfifo_data}, {24'd0, e_d});

      if (txfifo_wr === 1'b1) begin
        wlog.push_back(txfifo_data);
        wcyc.push_back(cyc);
      end
      if (frame_done === 1'b1) dcyc.push_back(cyc);

      if (!rst) begin
        m_hdr.delete();
        m_pay    = 0;
        m_active = 0;
        m_done   = 0;
        m_crdy   = 0;
        m_jr     = 1;
      end else begin
        m_jr   = 0;
        m_done = 0;
        if (m_active) begin
          if (m_hdr.size() > 0) begin
            if (e_wr) begin
              void'(m_hdr.pop_front());
              if (m_hdr.size() == 0 && m_pay == 0) begin
                m_active = 0;
                m_done   = 1;
              end
            end
          end else if (e_wr) begin
            m_pay--;
            if (m_pay == 0) begin
              m_active = 0;
              m_done   = 1;
            end
          end
        end else if (cmd_valid && m_crdy) begin
          m_hdr = '{8'hAA, 8'h00, cmd_code, cmd_data[31:24], cmd_data[23:16],
                    cmd_data[15:8], cmd_data[7:0], 8'h55};
          m_pay    = (cmd_code == BURST) ? int'(cmd_data[15:0]) : 0;
          m_active = 1;
          acyc.push_back(cyc);
        end
        m_crdy = !m_active;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] pay_seq;
  bit         fire_c;
  bit         fire_p;

  task automatic step();
    @(negedge clk);
    fire_c = cmd_valid && cmd_ready;
    fire_p = pay_valid && pay_ready;
    @(posedge clk);
    #1;
    if (fire_p) begin
      pay_seq  = pay_seq + 8'd1;
      pay_data = pay_seq;
    end
  endtask

  task automatic clear_logs();
    wlog.delete();
    wcyc.delete();
    dcyc.delete();
    acyc.delete();
  endtask

  // mode 0: free-running, 1: backpressure pattern, 2: payload bubbles,
  // 3: random full/valid and input churn, 4: reset after payload byte 2
  task automatic run_frame(input logic [7:0] code, input logic [31:0] data,
                           input int mode, output int acc);
    int k;
    int d0;
    int budget;
    d0        = dcyc.size();
    pay_seq   = 8'd0;
    pay_data  = 8'd0;
    cmd_code  = code;
    cmd_data  = data;
    cmd_valid = 1'b1;
    txfifo_full = 1'b0;
    pay_valid = (mode == 0 || mode == 1 || mode == 4);
    k = 0;
    do begin
      step();
      k++;
    end while (!fire_c && k < 40);
    cmd_valid = 1'b0;
    acc = cyc - 1;
    if (!fire_c) begin
      fail_to("accept_wait");
      return;
    end
    budget = 40 + 4 * int'(data[15:0]);
    k = 1;
    while (dcyc.size() == d0 && k < budget) begin
      case (mode)
        1: txfifo_full = (k >= 5 && k <= 7) || (k >= 17 && k <= 18);
        2: pay_valid = (k % 2) == 1;
        3: begin
          txfifo_full = ($urandom_range(0, 4) == 0);
          pay_valid   = ($urandom_range(0, 3) != 0);
          cmd_code    = 8'($urandom);
          cmd_data    = $urandom;
          txfifo_load = 13'($urandom);
        end
        default: ;
      endcase
      if (mode == 4 && wlog.size() == 11) begin
        pay_valid = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("busy_after_reset", {31'd0, busy}, 32'd0);
        chk("txfifo_wr_after_reset", {31'd0, txfifo_wr}, 32'd0);
        break;
      end
      step();
      k++;
    end
    txfifo_full = 1'b0;
    pay_valid   = 1'b0;
    if (mode != 4 && dcyc.size() == d0) fail_to("frame_done_wait");
  endtask

  task automatic check_hdr(input int w0, input int acc, input logic [7:0] code,
                           input logic [31:0] data, input bit timed);
    logic [63:0] h;
    h = {8'hAA, 8'h00, code, data, 8'h55};
    for (int i = 0; i < 8; i++) begin
      if (w0 + i < wlog.size()) begin
        chk("hdr_byte", {24'd0, wlog[w0+i]}, {24'd0, h[63-8*i -: 8]});
        if (timed) chk("hdr_cycle", wcyc[w0+i], acc + 1 + i);
      end
    end
  endtask

  initial begin
    int acc;
    int n;
    logic [7:0] code;
    logic [31:0] data;
    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_code = 8'h00;
    cmd_data = 32'h0;
    pay_valid = 1'b0;
    pay_data = 8'h00;
    pay_seq = 8'h00;
    txfifo_full = 1'b0;
    txfifo_load = 13'd0;
    step();
    step();
    mon_en = 1;
    step();
    rst = 1'b1;
    step();
    chk("cmd_ready_after_reset", {31'd0, cmd_ready}, 32'd1);
    chk("busy_idle", {31'd0, busy}, 32'd0);

    // header-only frame
    clear_logs();
    run_frame(8'h01, 32'h0001_0123, 0, acc);
    chk("hdr_only_count", wlog.size(), 8);
    check_hdr(0, acc, 8'h01, 32'h0001_0123, 1);
    if (dcyc.size() > 0) chk("hdr_only_done_cycle", dcyc[0], acc + 9);

    // burst of 16, no stalls
    clear_logs();
    run_frame(8'h02, 32'h0000_0010, 0, acc);
    chk("burst_count", wlog.size(), 24);
    check_hdr(0, acc, 8'h02, 32'h0000_0010, 1);
    for (int i = 0; i < 16; i++) begin
      if (8 + i < wlog.size()) begin
        chk("burst_byte", {24'd0, wlog[8+i]}, i);
        chk("burst_cycle", wcyc[8+i], acc + 9 + i);
      end
    end
    if (dcyc.size() > 0) chk("burst_done_cycle", dcyc[0], acc + 25);

    // same burst with backpressure: 3 stall cycles in header, 2 in payload
    clear_logs();
    run_frame(8'h02, 32'h0000_0010, 1, acc);
    chk("bp_count", wlog.size(), 24);
    check_hdr(0, acc, 8'h02, 32'h0000_0010, 0);
    for (int i = 0; i < 16; i++)
      if (8 + i < wlog.size()) chk("bp_byte", {24'd0, wlog[8+i]}, i);
    if (dcyc.size() > 0) chk("bp_done_cycle", dcyc[0], acc + 30);

    // payload bubbles, N=4
    clear_logs();
    run_frame(8'h02, 32'h1234_0004, 2, acc);
    chk("bubble_count", wlog.size(), 12);
    for (int i = 0; i < 4; i++)
      if (8 + i < wlog.size()) chk("bubble_byte", {24'd0, wlog[8+i]}, i);

    // reset after payload byte 2, then a clean frame
    clear_logs();
    run_frame(8'h02, 32'h0000_0010, 4, acc);
    chk("reset_partial_count", wlog.size(), 11);
    run_frame(8'h01, 32'hCAFE_F00D, 0, acc);
    chk("post_reset_count", wlog.size(), 19);
    check_hdr(11, acc, 8'h01, 32'hCAFE_F00D, 1);

    // back-to-back requests held high
    clear_logs();
    cmd_code  = 8'h01;
    cmd_data  = 32'h0BAD_BEEF;
    cmd_valid = 1'b1;
    n = 0;
    while (acyc.size() < 2 && n < 60) begin
      step();
      n++;
    end
    cmd_valid = 1'b0;
    if (acyc.size() < 2) fail_to("b2b_accept_wait");
    n = 0;
    while (dcyc.size() < 2 && n < 60) begin
      step();
      n++;
    end
    if (dcyc.size() < 2) fail_to("b2b_done_wait");
    else begin
      chk("b2b_accept_gap", acyc[1] - acyc[0], 9);
      chk("b2b_done_gap", dcyc[1] - dcyc[0], 9);
      chk("b2b_count", wlog.size(), 16);
    end

    // burst with N=0 is header-only
    clear_logs();
    run_frame(8'h02, 32'hABCD_0000, 0, acc);
    chk("n0_count", wlog.size(), 8);
    check_hdr(0, acc, 8'h02, 32'hABCD_0000, 1);
    if (dcyc.size() > 0) chk("n0_done_cycle", dcyc[0], acc + 9);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(0, 2))
        0: code = 8'h01;
        1: code = BURST;
        default: code = 8'($urandom);
      endcase
      data = {$urandom_range(0, 65535) == 0 ? 16'h0 : 16'($urandom),
              16'($urandom_range(0, 24))};
      if (f == 20) begin
        code = BURST;
        data[15:0] = 16'd300;
      end
      clear_logs();
      run_frame(code, data, 3, acc);
      chk("rand_count", wlog.size(), 8 + ((code == BURST) ? int'(data[15:0]) : 0));
      check_hdr(0, acc, code, data, 0);
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/transmitter.md
# transmitter

Host-bound framing engine for the proto245 TX path; the counterpart of the host-to-FPGA command `receiver`. It accepts a command (8-bit code plus 32-bit data) from FPGA logic and serialises it into an 8-byte frame. For burst frames (code 0x02) it then streams N raw payload bytes from a byte interface. It writes everything into the proto245 TX FIFO under `txfifo_full` backpressure.

## Interface
- `TX_FIFO_LOAD_W`, 13: width of `txfifo_load` (log2(4096)+1).
- `BURST_CODE`, 8'h02: command code whose frame is followed by a payload.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, synchronous, active-low (0 = reset).
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted on `cmd_valid && cmd_ready`.
- `cmd_code` in 8: frame code byte.
- `cmd_data` in 32: frame data word; for `BURST_CODE`, `cmd_data[15:0]` is the payload length N.
- `pay_valid` in 1: payload byte available.
- `pay_ready` out 1: payload byte consumed on `pay_valid && pay_ready`.
- `pay_data` in 8: payload byte.
- `busy` out 1: a frame is in progress (state ≠ IDLE).
- `frame_done` out 1: one-cycle pulse after the last byte of a frame is written.
- `txfifo_load` in `TX_FIFO_LOAD_W`: FIFO occupancy; informational, unused by the control logic.
- `txfifo_full` in 1: FIFO full; registered by proto245.
- `txfifo_wr` out 1: write strobe; one byte per cycle when high.
- `txfifo_data` out 8: byte written when `txfifo_wr` is high.

## Operation
- States: IDLE, HEADER, PAYLOAD.
- IDLE
  - `cmd_ready`=1.
  - On accept, latch code and data, clear byte index (3-bit) to 0, and go to HEADER.
- HEADER: emits the 8 wire bytes in this order, index 0..7:
  - 0xAA (prefix)
  - 0x00
  - code
  - data[31:24]
  - data[23:16]
  - data[15:8]
  - data[7:0]
  - 0x55 (suffix)
- HEADER write rule: `txfifo_wr = !txfifo_full`. `txfifo_data` = the byte at the current index. The index advances only on a write.
- After writing index 7:
  - If the code equals `BURST_CODE` and N≠0: load a 16-bit down-counter with N and go to PAYLOAD.
  - Otherwise: go to IDLE and pulse `frame_done`.
- PAYLOAD
  - `pay_ready = !txfifo_full`, and `txfifo_wr = pay_valid && !txfifo_full`.
  - `txfifo_data = pay_data` (combinational pass-through). The counter decrements on each write.
  - On the write with counter==1: go to IDLE and pulse `frame_done`.
- Outside PAYLOAD, `pay_ready`=0. Outside HEADER/PAYLOAD, `txfifo_wr`=0.
- Non-burst codes never consume payload bytes. A burst with N=0 is header-only.
- `cmd_data` is latched at accept; later input changes do not affect the frame in flight.
- `busy` = (state≠IDLE).

## Timing
- Reset values:
  - `cmd_ready`=0 during reset, then 1 in the first cycle after reset.
  - `pay_ready`=0, `busy`=0, `frame_done`=0, `txfifo_wr`=0, `txfifo_data`=8'h00.
  - State IDLE, index 0, counter 0.
- Latency: command accepted at edge T; prefix appears (`txfifo_wr`=1) in cycle T+1 if not full.
- With no backpressure, the header occupies cycles T+1..T+8, `frame_done` is high in T+9, and `cmd_ready` is high again in T+9.
- Throughput: a new command is accepted at edge T+9 at the earliest, giving 9 cycles per header-only frame.
- `txfifo_full` high: `txfifo_wr`=0 and `txfifo_data` holds the current byte. No byte is skipped or repeated.
- `pay_valid` low in PAYLOAD: the bubble is tolerated, with no write and no counter change.
- `txfifo_full` and `pay_valid` both high: no consumption, `pay_ready`=0.
- Counter is 16-bit; the maximum N=65535 must not wrap.
- Reset mid-frame: the next cycle returns to IDLE with all outputs at reset values. Bytes already written stay in the FIFO; the host resynchronises on 0xAA.
- `cmd_valid` asserted while busy: ignored (`cmd_ready`=0) and held by the requester.

## Test plan
- Header-only frame: code 0x01, data 0x00010123, `txfifo_full`=0.
  - Bytes AA 00 01 00 01 01 23 55 on 8 consecutive `txfifo_wr` cycles starting 1 cycle after accept.
  - `frame_done` one cycle later; `pay_ready` never high.
- Burst: code 0x02, data 0x00000010, `pay_data`=0..15 offered continuously.
  - Header AA 00 02 00 00 00 10 55, then bytes 0x00..0x0F on 16 consecutive writes.
  - `frame_done` after byte 0x0F; exactly 24 writes in total.
- Backpressure: `txfifo_full` pulsed high for 3 cycles during header index 4, and for 2 cycles during payload byte 5.
  - The written stream is identical to the unstalled case, with no write while full.
- Payload bubbles: `pay_valid` toggled 1/0 during a burst with N=4.
  - Exactly 4 payload writes, in order; `busy` stays 1 until the final write.
- Reset mid-burst: `rst`=0 for one cycle after payload byte 2.
  - All outputs return to reset values; the next command (code 0x01) produces a clean 8-byte frame starting with 0xAA.
- Back-to-back and edge lengths:
  - Two `cmd_valid` requests held high produce frames 9 cycles apart.
  - A burst with N=0 emits a header only.
  - `cmd_ready`=0 throughout the busy period.
